// File: rtl/ipsl_ddrphy_dll_update_req_gen.sv
// DLL update requester: raises a four-phase req toward the DLL update controller,
// periodically or on demand, only inside PHY idle windows, with an ack timeout.
module ipsl_ddrphy_dll_update_req_gen #(
  parameter int unsigned UPDATE_INTERVAL = 8192,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned TIMEOUT         = 64,
  parameter int unsigned TO_W            = 8
) (
  input  logic       rclk,
  input  logic       rst,
  input  logic       enable,
  input  logic       force_update,
  input  logic       phy_idle,
  input  logic       dll_update_ack,
  output logic       dll_update_req,
  output logic       update_busy,
  output logic       update_done,
  output logic       update_timeout,
  output logic [7:0] update_count
);

  localparam int unsigned COUNT_W = 8;
  localparam logic [CNT_W-1:0]   INT_LAST  = CNT_W'(UPDATE_INTERVAL - 1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    REQ      = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  int_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              force_pend;
  logic              forced_run;
  logic              to_flag;

  // forced_run remembers that the current attempt was forced, so dropping enable cannot cancel it
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      int_cnt        <= '0;
      to_cnt         <= '0;
      force_pend     <= 1'b0;
      forced_run     <= 1'b0;
      to_flag        <= 1'b0;
      dll_update_req <= 1'b0;
      update_busy    <= 1'b0;
      update_done    <= 1'b0;
      update_timeout <= 1'b0;
      update_count   <= '0;
    end else begin
      update_done    <= 1'b0;
      update_timeout <= 1'b0;
      force_pend     <= force_pend | force_update;

      case (state)
        IDLE: begin
          if (force_pend || force_update || (enable && (int_cnt == INT_LAST))) begin
            state       <= WAIT_WIN;
            update_busy <= 1'b1;
            int_cnt     <= '0;
            force_pend  <= 1'b0;
            forced_run  <= force_pend | force_update;
          end else if (enable) begin
            int_cnt <= int_cnt + CNT_W'(1);
          end else begin
            int_cnt <= '0;
          end
        end

        WAIT_WIN: begin
          // Never re-raise req while the responder still holds ack
          if (phy_idle && !dll_update_ack) begin
            state          <= REQ;
            dll_update_req <= 1'b1;
            to_cnt         <= '0;
          end else if (!enable && !forced_run && !force_pend) begin
            state       <= IDLE;
            update_busy <= 1'b0;
          end
        end

        REQ: begin
          if (dll_update_ack) begin
            state          <= RELEASE;
            dll_update_req <= 1'b0;
            to_flag        <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state          <= RELEASE;
            dll_update_req <= 1'b0;
            to_flag        <= 1'b1;
            update_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        RELEASE: begin
          // Late acks after a timeout are absorbed here
          if (!dll_update_ack) begin
            state       <= IDLE;
            update_busy <= 1'b0;
            forced_run  <= 1'b0;
            if (!to_flag) begin
              update_done <= 1'b1;
              if (update_count != COUNT_MAX) begin
                update_count <= update_count + COUNT_W'(1);
              end
            end
          end
        end

        default: begin
          state          <= IDLE;
          dll_update_req <= 1'b0;
          update_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipsl_ddrphy_dll_update_req_gen.sv
// Directed bench for the DLL update requester; handshake outcomes are tracked by a scoreboard.
module tb_ipsl_ddrphy_dll_update_req_gen;

  localparam int unsigned UI = 16;
  localparam int unsigned CW = 5;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;

  logic       rclk;
  logic       rst;
  logic       enable;
  logic       force_update;
  logic       phy_idle;
  logic       dll_update_ack;
  logic       dll_update_req;
  logic       update_busy;
  logic       update_done;
  logic       update_timeout;
  logic [7:0] update_count;

  typedef struct packed {
    logic       is_done;
    logic [7:0] count;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  int         cyc;
  int         req_hi;
  bit         auto_ack;
  logic [7:0] model_count;

  ipsl_ddrphy_dll_update_req_gen #(
    .UPDATE_INTERVAL(UI),
    .CNT_W          (CW),
    .TIMEOUT        (TO),
    .TO_W           (TW)
  ) dut (
    .rclk          (rclk),
    .rst           (rst),
    .enable        (enable),
    .force_update  (force_update),
    .phy_idle      (phy_idle),
    .dll_update_ack(dll_update_ack),
    .dll_update_req(dll_update_req),
    .update_busy   (update_busy),
    .update_done   (update_done),
    .update_timeout(update_timeout),
    .update_count  (update_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_done);
    if (is_done && model_count != 8'hff) model_count = model_count + 8'd1;
    sb.push_back(exp_t'{is_done: is_done, count: model_count});
  endtask

  // One clock: sample after the edge, score any completion pulse, then run the responder
  task automatic tick();
    exp_t e;
    @(posedge rclk);
    #1;
    cyc++;
    if (update_done || update_timeout) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({update_done, update_timeout}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_pulse", 32'({update_done, update_timeout, update_count}),
              32'({e.is_done, ~e.is_done, e.count}));
      end
    end
    if (auto_ack) begin
      if (dll_update_req) begin
        req_hi++;
        if (req_hi >= 3) dll_update_ack = 1'b1;
      end else begin
        req_hi = 0;
        dll_update_ack = 1'b0;
      end
    end
  endtask

  task automatic wait_req(input logic val, input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (dll_update_req === val) found = 1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (update_busy === 1'b0) found = 1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Force pulse in IDLE with phy_idle=1: WAIT_WIN after one edge, req after the second
  task automatic force_req(input string tag);
    force_update = 1'b1;
    tick();
    force_update = 1'b0;
    check({tag, "_wait_win"}, 32'({update_busy, dll_update_req}), 32'b10);
    tick();
    check({tag, "_req"}, 32'(dll_update_req), 32'd1);
  endtask

  initial begin
    int r1;
    int hi;
    checks = 0; errors = 0; cyc = 0; req_hi = 0; auto_ack = 0; model_count = 8'd0;
    rst = 1'b1; enable = 1'b0; force_update = 1'b0; phy_idle = 1'b0; dll_update_ack = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'({dll_update_req, update_busy, update_done, update_timeout, update_count}), 32'd0);

    // 1: periodic handshakes with auto responder
    rst = 1'b0; enable = 1'b1; phy_idle = 1'b1; auto_ack = 1;
    push(1); push(1); push(1);
    wait_req(1'b1, 40, "t1_first_req");
    r1 = cyc;
    wait_req(1'b0, 10, "t1_req_fall1");
    wait_req(1'b1, 40, "t1_second_req");
    check("t1_period1", 32'(cyc - r1), 32'd21);
    r1 = cyc;
    wait_req(1'b0, 10, "t1_req_fall2");
    wait_req(1'b1, 40, "t1_third_req");
    check("t1_period2", 32'(cyc - r1), 32'd21);
    wait_idle(10, "t1_idle");
    check("t1_sb_drained", 32'(sb.size()), 32'd0);

    // 2: window closed after interval expiry
    phy_idle = 1'b0;
    push(1);
    begin
      bit found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        tick();
        if (update_busy === 1'b1) found = 1;
      end
      check("t2_busy", 32'(found), 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t2_held_no_req", 32'({update_busy, dll_update_req}), 32'b10);
    end
    phy_idle = 1'b1;
    tick();
    check("t2_req_on_window", 32'(dll_update_req), 32'd1);
    wait_idle(20, "t2_idle");
    enable = 1'b0;
    check("t2_sb_drained", 32'(sb.size()), 32'd0);

    // 3: no ack -> timeout, late ack absorbed, next request normal
    auto_ack = 0;
    push(0);
    force_req("t3");
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dll_update_req !== 1'b1) break;
      hi++;
    end
    check("t3_req_cycles", 32'(hi), 32'(TO));
    check("t3_release_busy", 32'(update_busy), 32'd1);
    dll_update_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_late_ack_absorb", 32'({update_busy, dll_update_req}), 32'b10);
    end
    dll_update_ack = 1'b0;
    tick();
    check("t3_back_idle", 32'(update_busy), 32'd0);
    check("t3_count_kept", 32'(update_count), 32'(model_count));
    auto_ack = 1;
    push(1);
    force_req("t3_next");
    wait_idle(20, "t3_next_idle");
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // 5: ack on the timeout edge wins; ack held keeps RELEASE
    auto_ack = 0;
    push(1);
    force_req("t5");
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      check("t5_req_hold", 32'(dll_update_req), 32'd1);
    end
    dll_update_ack = 1'b1;
    tick();
    check("t5_ack_wins", 32'({dll_update_req, update_timeout, update_done}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_release_hold", 32'({update_busy, dll_update_req}), 32'b10);
    end
    dll_update_ack = 1'b0;
    tick();
    check("t5_idle", 32'(update_busy), 32'd0);
    check("t5_sb_drained", 32'(sb.size()), 32'd0);

    // 4: enable=0, force plus a second force during REQ -> exactly two handshakes
    auto_ack = 1;
    push(1); push(1);
    force_req("t4");
    force_update = 1'b1;
    tick();
    force_update = 1'b0;
    wait_idle(20, "t4_first_idle");
    wait_req(1'b1, 20, "t4_second_req");
    wait_idle(20, "t4_second_idle");
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t4_no_third", 32'({update_busy, dll_update_req}), 32'd0);
    end
    check("t4_sb_drained", 32'(sb.size()), 32'd0);

    // 6: async reset in REQ
    auto_ack = 0;
    force_req("t6");
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_clear", 32'({dll_update_req, update_busy, update_count}), 32'd0);
    model_count = 8'd0;
    @(posedge rclk);
    #1;
    rst = 1'b0;
    auto_ack = 1;
    enable = 1'b1;
    push(1);
    wait_req(1'b1, 40, "t6_restart_req");
    wait_idle(20, "t6_restart_idle");
    check("t6_count", 32'(update_count), 32'd1);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
